// File: rtl/output_buffer_if.sv
// output_buffer_if: streaming read-out channel of output_buffer.
// The buffer drives data/valid/last as master; the consumer drives ready.
interface output_buffer_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/output_buffer.sv
// output_buffer: DEPTH x DATA_W result store written by the accumulator and
// drained as a valid/ready stream of drain_len words starting at drain_base.
// Optional feature: define OUTPUT_BUFFER_CLEAR_ON_READ_EN to make draining
// destructive (each streamed entry drops its entry_valid flag).
module output_buffer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      output_data,
  input  logic [ADDR_W-1:0]      output_buffer_addr,
  input  logic                   output_buffer_enable,
  input  logic                   drain_start,
  input  logic [ADDR_W-1:0]      drain_base,
  input  logic [ADDR_W:0]        drain_len,
  output_buffer_if.master        out_if,
  output logic                   busy,
  output logic                   drain_done,
  output logic [(2**ADDR_W)-1:0] entry_valid
);
  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [ADDR_W:0]   REM_ZERO = {(ADDR_W + 1){1'b0}};
  localparam logic [ADDR_W:0]   REM_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   DEPTH_L  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] PTR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W - 1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [DATA_W-1:0]   mem_r [DEPTH];
  logic [ADDR_W-1:0]   ptr_r;
  logic [ADDR_W:0]     rem_r;
  logic [ADDR_W:0]     len_clamped_s;
  logic [DATA_W-1:0]   out_data_r;
  logic                out_valid_r;
  logic                out_last_r;
  logic                busy_r;
  logic                drain_done_r;
  logic [DEPTH-1:0]    entry_valid_r;
  logic                load_s;
  logic                finish_s;
  logic                start_s;
  logic                bypass_s;

  assign len_clamped_s = (drain_len > DEPTH_L) ? DEPTH_L : drain_len;
  assign start_s       = (state_r == ST_IDLE) && drain_start;
  // A write landing on the entry being loaded this cycle must be seen by the stream.
  assign bypass_s      = output_buffer_enable && (output_buffer_addr == ptr_r);

  assign out_if.out_data  = out_data_r;
  assign out_if.out_valid = out_valid_r;
  assign out_if.out_last  = out_last_r;
  assign busy             = busy_r;
  assign drain_done       = drain_done_r;
  assign entry_valid      = entry_valid_r;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic and per-cycle load/finish decisions.
  always_comb begin
    state_s  = state_r;
    load_s   = 1'b0;
    finish_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (drain_start) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        // The output slot is free when empty or when its beat is being taken.
        if (!out_valid_r || out_if.out_ready) begin
          if (rem_r != REM_ZERO) begin
            load_s = 1'b1;
          end else begin
            finish_s = 1'b1;
            state_s  = ST_DONE;
          end
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Drain pointer, beat counter, registered stream outputs and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r        <= PTR_ZERO;
      rem_r        <= REM_ZERO;
      out_data_r   <= {DATA_W{1'b0}};
      out_valid_r  <= 1'b0;
      out_last_r   <= 1'b0;
      busy_r       <= 1'b0;
      drain_done_r <= 1'b0;
    end else begin
      if (start_s) begin
        ptr_r <= drain_base;
        rem_r <= len_clamped_s;
      end else if (load_s) begin
        out_data_r  <= bypass_s ? output_data : mem_r[ptr_r];
        out_valid_r <= 1'b1;
        out_last_r  <= (rem_r == REM_ONE);
        ptr_r       <= ptr_r + PTR_ONE;
        rem_r       <= rem_r - REM_ONE;
      end else if (finish_s) begin
        out_valid_r <= 1'b0;
        out_last_r  <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
      busy_r       <= (state_s != ST_IDLE);
      drain_done_r <= (state_s == ST_DONE);
    end
  end

  // Storage array; contents survive reset, entry_valid marks them stale.
  always_ff @(posedge clk) begin
    if (output_buffer_enable && !rst) begin
      mem_r[output_buffer_addr] <= output_data;
    end
  end

  // Per-entry written flags; a same-cycle write overrides a read clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      entry_valid_r <= {DEPTH{1'b0}};
    end else begin
`ifdef OUTPUT_BUFFER_CLEAR_ON_READ_EN
      if (load_s) begin
        entry_valid_r[ptr_r] <= 1'b0;
      end
`endif
      if (output_buffer_enable) begin
        entry_valid_r[output_buffer_addr] <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_output_buffer.sv
// tb_output_buffer: self-checking bench for output_buffer.
module tb_output_buffer;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] wdata;
  logic [AW-1:0] waddr;
  logic          we;
  logic          drain_start;
  logic [AW-1:0] drain_base;
  logic [AW:0]   drain_len;
  logic          busy;
  logic          drain_done;
  logic [15:0]   entry_valid;

  output_buffer_if #(.DATA_W(DW)) bus ();

  output_buffer #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .output_data          (wdata),
    .output_buffer_addr   (waddr),
    .output_buffer_enable (we),
    .drain_start          (drain_start),
    .drain_base           (drain_base),
    .drain_len            (drain_len),
    .out_if               (bus.master),
    .busy                 (busy),
    .drain_done           (drain_done),
    .entry_valid          (entry_valid)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: plain array of words plus a written-flag word.
  logic [DW-1:0] mem_m [DEPTH];
  logic [15:0]   ev_m;
  logic [DW-1:0] got_q [$];
  logic          last_q [$];

  typedef struct {
    logic        rst;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] data;
    logic        start;
    logic [4:0]  len;
    logic        e_valid;
    logic        e_last;
    logic        e_busy;
    logic        e_done;
    logic        chk_data;
    logic [31:0] e_data;
    logic        chk_ev;
    logic [15:0] e_ev;
  } vec_t;

  vec_t tbl [12];

  function automatic vec_t vec(input int rs, input int w, input int ad, input int dt,
                               input int st, input int ln, input int evl, input int el,
                               input int eb, input int ed, input int cd, input int edt,
                               input int ce, input int eev);
    vec_t v;
    v.rst = rs[0]; v.we = w[0]; v.addr = 4'(ad); v.data = 32'(dt);
    v.start = st[0]; v.len = 5'(ln);
    v.e_valid = evl[0]; v.e_last = el[0]; v.e_busy = eb[0]; v.e_done = ed[0];
    v.chk_data = cd[0]; v.e_data = 32'(edt); v.chk_ev = ce[0]; v.e_ev = 16'(eev);
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    @(negedge clk);
    we = 1'b0;
    mem_m[a] = d;
    ev_m[a]  = 1'b1;
  endtask

  // Start a drain and collect accepted beats; mode 0 ready high, 1 random,
  // 2 stall three cycles while the second beat is presented.
  task automatic run_drain(input logic [3:0] base, input logic [4:0] len,
                           input int mode, input string tag);
    logic [DW-1:0] exp_q [$];
    int            n;
    int            stall;
    bit            fin;
    logic          pv, pr, pl, r;
    logic [DW-1:0] pd;
    n = (len > 5'd16) ? 16 : int'(len);
    for (int i = 0; i < n; i++) exp_q.push_back(mem_m[(int'(base) + i) % DEPTH]);
    got_q.delete();
    last_q.delete();
    drain_start = 1'b1; drain_base = base; drain_len = len; bus.out_ready = 1'b0;
    @(negedge clk);
    drain_start = 1'b0;
    pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0; fin = 1'b0; stall = 0;
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      if (pv && !pr) begin
        check({tag, " held valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, " held data"}, bus.out_data, pd);
        check({tag, " held last"}, 32'(bus.out_last), 32'(pl));
      end
      if (drain_done) begin
        fin = 1'b1;
        check({tag, " busy at done"}, 32'(busy), 32'd1);
      end
      case (mode)
        1: r = 1'($urandom_range(0, 1));
        2: begin
          r = !(bus.out_valid && got_q.size() == 1 && stall < 3);
          if (!r) stall++;
        end
        default: r = 1'b1;
      endcase
      if (bus.out_valid && r) begin
        got_q.push_back(bus.out_data);
        last_q.push_back(bus.out_last);
      end
      pv = bus.out_valid; pr = r; pd = bus.out_data; pl = bus.out_last;
      bus.out_ready = r;
      @(negedge clk);
    end
    if (!fin) begin
      errors++;
      checks++;
      $display("FAIL %s timeout: got no drain_done expected pulse", tag);
    end
    check({tag, " busy after"}, 32'(busy), 32'd0);
    check({tag, " done after"}, 32'(drain_done), 32'd0);
    check({tag, " beats"}, 32'(got_q.size()), 32'(n));
    for (int i = 0; i < n && i < got_q.size(); i++) begin
      check($sformatf("%s beat%0d", tag, i), got_q[i], exp_q[i]);
      check($sformatf("%s last%0d", tag, i), 32'(last_q[i]), 32'(i == n - 1));
    end
`ifdef OUTPUT_BUFFER_CLEAR_ON_READ_EN
    for (int i = 0; i < n; i++) ev_m[(int'(base) + i) % DEPTH] = 1'b0;
`endif
    check({tag, " entry_valid"}, 32'(entry_valid), 32'(ev_m));
  endtask

  initial begin
    int ev_end;
    rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
    drain_start = 1'b0; drain_base = '0; drain_len = '0; bus.out_ready = 1'b0;
    ev_m = 16'h0000;
`ifdef OUTPUT_BUFFER_CLEAR_ON_READ_EN
    ev_end = 0;
`else
    ev_end = 'hF;
`endif
    //             rs we ad dt  st ln  vl ls by dn cd data ce ev
    tbl[0]  = vec(1, 0, 0, 0,  0, 0,  0, 0, 0, 0, 1, 0,  1, 0);
    tbl[1]  = vec(0, 1, 0, 10, 0, 0,  0, 0, 0, 0, 0, 0,  1, 'h1);
    tbl[2]  = vec(0, 1, 1, 20, 0, 0,  0, 0, 0, 0, 0, 0,  1, 'h3);
    tbl[3]  = vec(0, 1, 2, 30, 0, 0,  0, 0, 0, 0, 0, 0,  1, 'h7);
    tbl[4]  = vec(0, 1, 3, 40, 0, 0,  0, 0, 0, 0, 0, 0,  1, 'hF);
    tbl[5]  = vec(0, 0, 0, 0,  1, 4,  0, 0, 1, 0, 0, 0,  1, 'hF);
    tbl[6]  = vec(0, 0, 0, 0,  0, 4,  1, 0, 1, 0, 1, 10, 0, 0);
    tbl[7]  = vec(0, 0, 0, 0,  0, 4,  1, 0, 1, 0, 1, 20, 0, 0);
    tbl[8]  = vec(0, 0, 0, 0,  0, 4,  1, 0, 1, 0, 1, 30, 0, 0);
    tbl[9]  = vec(0, 0, 0, 0,  0, 4,  1, 1, 1, 0, 1, 40, 0, 0);
    tbl[10] = vec(0, 0, 0, 0,  0, 4,  0, 0, 1, 1, 0, 0,  0, 0);
    tbl[11] = vec(0, 0, 0, 0,  0, 4,  0, 0, 0, 0, 0, 0,  1, ev_end);

    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      rst = tbl[i].rst; we = tbl[i].we; waddr = tbl[i].addr; wdata = tbl[i].data;
      drain_start = tbl[i].start; drain_base = 4'd0; drain_len = tbl[i].len;
      bus.out_ready = 1'b1;
      @(negedge clk);
      check($sformatf("v%0d valid", i), 32'(bus.out_valid), 32'(tbl[i].e_valid));
      check($sformatf("v%0d last", i), 32'(bus.out_last), 32'(tbl[i].e_last));
      check($sformatf("v%0d busy", i), 32'(busy), 32'(tbl[i].e_busy));
      check($sformatf("v%0d done", i), 32'(drain_done), 32'(tbl[i].e_done));
      if (tbl[i].chk_data) check($sformatf("v%0d data", i), bus.out_data, tbl[i].e_data);
      if (tbl[i].chk_ev) check($sformatf("v%0d ev", i), 32'(entry_valid), 32'(tbl[i].e_ev));
    end
    rst = 1'b0; we = 1'b0; drain_start = 1'b0;

    // Known contents everywhere before any drain reads them.
    for (int a = 0; a < DEPTH; a++) wr(4'(a), $urandom);

    wr(4'd14, 32'hA); wr(4'd15, 32'hB); wr(4'd0, 32'hC); wr(4'd1, 32'hD);
    run_drain(4'd14, 5'd4, 0, "wrap");

    run_drain(4'd4, 5'd3, 2, "stall");

    // Empty drain; a second start while busy is dropped.
    bus.out_ready = 1'b1;
    drain_start = 1'b1; drain_base = 4'd0; drain_len = 5'd0;
    @(negedge clk);
    drain_len = 5'd4;
    check("len0 busy1", 32'(busy), 32'd1);
    check("len0 valid1", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    drain_start = 1'b0;
    check("len0 busy2", 32'(busy), 32'd1);
    check("len0 done", 32'(drain_done), 32'd1);
    check("len0 valid2", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check("len0 idle", 32'(busy), 32'd0);
    @(negedge clk);
    check("ignored start busy", 32'(busy), 32'd0);
    check("ignored start valid", 32'(bus.out_valid), 32'd0);

    // Same-cycle write into the entry being loaded.
    drain_start = 1'b1; drain_base = 4'd8; drain_len = 5'd1;
    @(negedge clk);
    drain_start = 1'b0;
    we = 1'b1; waddr = 4'd8; wdata = 32'hBEEF_0008;
    @(negedge clk);
    we = 1'b0; mem_m[8] = 32'hBEEF_0008; ev_m[8] = 1'b1;
    check("bypass valid", 32'(bus.out_valid), 32'd1);
    check("bypass data", bus.out_data, 32'hBEEF_0008);
    check("bypass last", 32'(bus.out_last), 32'd1);
    @(negedge clk);
    check("bypass done", 32'(drain_done), 32'd1);
    @(negedge clk);
    check("bypass ev8", 32'(entry_valid[8]), 32'd1);

    run_drain(4'd3, 5'd20, 0, "clamp");

    for (int it = 0; it < 25; it++) begin
      int nw;
      nw = $urandom_range(0, 5);
      for (int k = 0; k < nw; k++) wr(4'($urandom_range(0, 15)), $urandom);
      run_drain(4'($urandom_range(0, 15)), 5'($urandom_range(0, 20)), 1,
                $sformatf("rnd%0d", it));
    end

    // Reset in the middle of a drain, with a colliding write.
    bus.out_ready = 1'b1;
    drain_start = 1'b1; drain_base = 4'd0; drain_len = 5'd4;
    @(negedge clk);
    drain_start = 1'b0;
    @(negedge clk);
    check("pre-rst valid", 32'(bus.out_valid), 32'd1);
    rst = 1'b1; we = 1'b1; waddr = 4'd5; wdata = 32'h5555_5555;
    @(negedge clk);
    rst = 1'b0; we = 1'b0; ev_m = 16'h0000;
    check("rst valid", 32'(bus.out_valid), 32'd0);
    check("rst last", 32'(bus.out_last), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(drain_done), 32'd0);
    check("rst data", bus.out_data, 32'd0);
    check("rst ev", 32'(entry_valid), 32'd0);
    @(negedge clk);
    check("post-rst idle", 32'(busy), 32'd0);
    run_drain(4'd5, 5'd1, 0, "rst-write");

    wr(4'd0, 32'd1); wr(4'd1, 32'd2); wr(4'd2, 32'd3); wr(4'd3, 32'd4);
    run_drain(4'd0, 5'd4, 0, "evdrain");
    check("evdrain flags", 32'(entry_valid), 32'(ev_end));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end
endmodule

// File: doc/output_buffer.md
OUTPUT_BUFFER -- requirements
Module: output_buffer

Interface
REQ-001 Parameter DATA_W, default 32, result word width, matching accumulator output_data.
REQ-002 Parameter ADDR_W, default 4, address width; DEPTH = 2**ADDR_W = 16 entries.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 output_data  input  DATA_W  write data from accumulator.
REQ-007 output_buffer_addr  input  ADDR_W  write address.
REQ-008 output_buffer_enable  input  1  write strobe, one word per cycle.
REQ-009 drain_start  input  1  single-cycle request to stream entries out.
REQ-010 drain_base  input  ADDR_W  first entry to stream.
REQ-011 drain_len  input  ADDR_W+1  entry count; 0 = empty drain; >DEPTH clamps to DEPTH.
REQ-012 out_data  output  DATA_W  streamed word, registered.
REQ-013 out_valid  output  1  out_data valid.
REQ-014 out_ready  input  1  consumer accepts the current beat.
REQ-015 out_last  output  1  marks final beat of a drain.
REQ-016 busy  output  1  high whenever state is not IDLE.
REQ-017 drain_done  output  1  one-cycle pulse at drain completion.
REQ-018 entry_valid  output  DEPTH  per-entry written flag.

Function
REQ-019 Storage: DEPTH x DATA_W registers; a write on output_buffer_enable updates mem[output_buffer_addr] and sets entry_valid[output_buffer_addr] at that edge.
REQ-020 Writes are accepted in every state, including during a drain.
REQ-021 FSM states IDLE, DRAIN, DONE; IDLE->DRAIN on drain_start; DRAIN->DONE after last beat accepted; DONE->IDLE unconditionally after one cycle.
REQ-022 drain_start sampled only in IDLE; ignored while busy.
REQ-023 On start edge: ptr <= drain_base, remaining <= min(drain_len, DEPTH).
REQ-024 In DRAIN, on each edge with (!out_valid || out_ready) and remaining>0: out_data <= mem[ptr], out_valid <= 1, out_last <= (remaining==1), ptr <= ptr+1 mod DEPTH, remaining--.
REQ-025 First out_valid asserts after the second rising edge counting the drain_start sampling edge; full throughput of one beat per cycle with out_ready held high.
REQ-026 When remaining==0 and the held beat is accepted (out_valid && out_ready), out_valid and out_last clear and state moves to DONE.
REQ-027 drain_len==0: DRAIN with no beats, immediate transition to DONE at next edge.
REQ-028 out_data, out_valid and out_last are held stable while out_valid && !out_ready.
REQ-029 Address wrap: ptr wraps from DEPTH-1 to 0 (base 14, len 4 reads 14,15,0,1).
REQ-030 Write-first bypass: a same-cycle write to the entry being loaded supplies the new data to out_data.
REQ-031 drain_done is high exactly in the DONE cycle; busy is high in DRAIN and DONE.

Reset
REQ-032 rst at any edge, including mid-drain: state IDLE, ptr 0, remaining 0, out_valid 0, out_last 0, drain_done 0, out_data 0, entry_valid all 0.
REQ-033 Memory contents are not reset; entry_valid 0 marks them stale.
REQ-034 rst dominates a simultaneous write or drain_start in the same cycle.

Configuration
REQ-035 Macro OUTPUT_BUFFER_CLEAR_ON_READ_EN.
REQ-036 Defined: each beat load clears entry_valid[ptr] unless a same-cycle write to that entry occurs (write wins, flag stays set).
REQ-037 Undefined: entry_valid changes only by writes and reset; draining is non-destructive.

Verification
REQ-038 Write 10,20,30,40 to addr 0..3, drain base 0 len 4, out_ready=1 -> beats 10,20,30,40 on consecutive cycles, out_last on 40, drain_done one cycle after.
REQ-039 Write 0xA at 14,0xB at 15,0xC at 0,0xD at 1; drain base 14 len 4 -> A,B,C,D (wrap).
REQ-040 Drain len 3, out_ready low 3 cycles on beat 2 -> beat 2 held stable, no loss/duplication, 3 beats total.
REQ-041 drain_len 0 -> no out_valid, drain_done pulses, busy high 2 cycles; drain_start while busy ignored.
REQ-042 rst asserted mid-drain after beat 1 -> next cycle out_valid 0, busy 0, entry_valid 0x0000.
REQ-043 With OUTPUT_BUFFER_CLEAR_ON_READ_EN, drain entries 0..3 -> entry_valid bits 0..3 cleared; without it they stay set.
